up_mem_dump: RTL
================

// Module: up_mem_dump
// PURPOSE
//  Read-back counterpart to the UART program loader. On request, walks the program
//  memory from START_ADDR to LAST_ADDR, serialises each byte to the UART transmitter
//  over the transmit/busy_tx handshake, then appends an 8-bit checksum byte.
//  Sits between the up memory read port and the UART tx; used to verify a loaded image.
// PARAMETERS
//  ADDR_W      8    memory address width
//  DATA_W      8    memory/UART data width
//  START_ADDR  0    first address dumped
//  LAST_ADDR   255  last address dumped, inclusive; must be >= START_ADDR
//  SEND_SUM    1    1: append checksum byte after last data byte; 0: no checksum
// PORTS
//  clk       in   1       system clock, all logic on rising edge
//  rst       in   1       asynchronous, active-high reset
//  dump      in   1       start request; rising edge starts a dump
//  mem_data  in   DATA_W  memory read data, valid 1 cycle after mem_rd
//  busy_tx   in   1       UART tx busy; rises the cycle after transmit
//  mem_addr  out  ADDR_W  memory read address
//  mem_rd    out  1       1-cycle read strobe
//  transmit  out  1       1-cycle pulse: load_out valid, start tx
//  load_out  out  DATA_W  byte to transmit, held stable until the next transmit
//  active    out  1       high from start until done
//  done      out  1       1-cycle pulse after the final byte's busy_tx falls
// BEHAVIOUR
//  Reset (async, any state): FSM=IDLE, mem_addr=START_ADDR, sum=0, dump edge reg=0.
//   All outputs are 0 except mem_addr.
//  FSM: IDLE -> RD -> LAT -> SEND -> GAP -> WAIT -> (RD | SUM | FIN) -> IDLE.
//   IDLE: on dump rising edge (dump=1, dump_q=0): mem_addr=START_ADDR, sum=0,
//     active=1 -> RD.
//   RD: mem_rd=1 for exactly 1 cycle at mem_addr -> LAT.
//   LAT: capture mem_data into load_out; sum <= sum+mem_data (mod 2^DATA_W) -> SEND.
//   SEND: wait while busy_tx=1; when busy_tx=0, transmit=1 for 1 cycle -> GAP.
//   GAP: 1 cycle, busy_tx ignored (tx raises busy here) -> WAIT.
//   WAIT: hold while busy_tx=1; when busy_tx=0:
//     mem_addr!=LAST_ADDR: mem_addr+1 -> RD.
//     mem_addr==LAST_ADDR and SEND_SUM=1 -> SUM.
//     mem_addr==LAST_ADDR and SEND_SUM=0 -> FIN.
//   SUM: load_out=sum, then the same SEND/GAP/WAIT handshake; WAIT then exits -> FIN.
//   FIN: done=1 for 1 cycle, active=0, mem_addr=START_ADDR -> IDLE.
//  Latency: dump edge to first transmit = 4 cycles when busy_tx=0.
//  Byte count: LAST_ADDR-START_ADDR+1 data bytes, plus 1 if SEND_SUM.
//  Address never wraps: LAST_ADDR=2^ADDR_W-1 terminates without an overflow increment.
//  dump edges while active=1 are ignored. dump held high does not retrigger;
//   a new dump requires a low->high transition.
//  busy_tx already high at start: first transmit waits in SEND until it falls.
//  rst during a dump aborts immediately: no done pulse, transmit drops to 0.
//  rst and dump edge in the same cycle: rst wins, dump is lost.
// TESTING
//  1 mem[i]=i, START=0, LAST=3, tx model busy for 10 cycles ->
//    load_out 00,01,02,03 then sum 06; one done pulse.
//  2 START=0, LAST=255, mem=FF everywhere -> 256 bytes of FF, then checksum 00;
//    no address wrap; mem_addr returns to 00.
//  3 dump held high 2000 cycles -> exactly one dump; toggling dump while active
//    does not start a second dump.
//  4 busy_tx=1 when dump rises, released after 50 cycles -> first transmit
//    comes 1 cycle after busy_tx falls.
//  5 rst asserted after the 2nd transmit -> transmit/active/done=0 immediately;
//    a new dump restarts at START_ADDR.
//  6 SEND_SUM=0, START=LAST=0x10, mem[0x10]=AA -> a single transmit of AA, then done.

Source files
------------

// File: rtl/up_mem_dump.sv
// up_mem_dump: reads program memory from START_ADDR to LAST_ADDR and sends each byte
// to the UART transmitter over the transmit/busy_tx handshake. An 8-bit running
// checksum byte can optionally follow the last data byte.
module up_mem_dump #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned LAST_ADDR  = 255,
  parameter bit          SEND_SUM   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dump,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              busy_tx,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              transmit,
  output logic [DATA_W-1:0] load_out,
  output logic              active,
  output logic              done
);

  localparam logic [ADDR_W-1:0] StartA = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] LastA  = ADDR_W'(LAST_ADDR);

  typedef enum logic [2:0] {
    StIdle, StRd, StLat, StSend, StGap, StWait, StSum, StFin
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic [DATA_W-1:0]   load_q, load_d;
  logic                tx_q, tx_d;
  logic                sum_phase_q, sum_phase_d;  // set while the checksum byte is in flight
  logic                dump_q;

  // State and datapath registers; reset aborts any dump in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= StartA;
      sum_q       <= '0;
      load_q      <= '0;
      tx_q        <= 1'b0;
      sum_phase_q <= 1'b0;
      dump_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      sum_q       <= sum_d;
      load_q      <= load_d;
      tx_q        <= tx_d;
      sum_phase_q <= sum_phase_d;
      dump_q      <= dump;
    end
  end

  // Next-state logic for the read / send / wait walk through memory.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    sum_d       = sum_q;
    load_d      = load_q;
    tx_d        = 1'b0;
    sum_phase_d = sum_phase_q;
    unique case (state_q)
      StIdle: begin
        // Only a low->high transition starts a dump; a held level is ignored.
        if (dump && !dump_q) begin
          addr_d      = StartA;
          sum_d       = '0;
          sum_phase_d = 1'b0;
          state_d     = StRd;
        end
      end
      StRd:   state_d = StLat;
      StLat: begin
        load_d  = mem_data;
        sum_d   = sum_q + mem_data;
        state_d = StSend;
      end
      StSend: begin
        if (!busy_tx) begin
          tx_d    = 1'b1;
          state_d = StGap;
        end
      end
      // The transmitter raises busy_tx only after seeing transmit, so skip one cycle.
      StGap:  state_d = StWait;
      StWait: begin
        if (!busy_tx) begin
          if (sum_phase_q) begin
            state_d = StFin;
          end else if (addr_q != LastA) begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = StRd;
          end else if (SEND_SUM) begin
            state_d = StSum;
          end else begin
            state_d = StFin;
          end
        end
      end
      StSum: begin
        load_d      = sum_q;
        sum_phase_d = 1'b1;
        state_d     = StSend;
      end
      StFin: begin
        addr_d  = StartA;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state; transmit is registered so it is a clean 1-cycle pulse.
  always_comb begin
    mem_addr = addr_q;
    mem_rd   = (state_q == StRd);
    transmit = tx_q;
    load_out = load_q;
    active   = (state_q != StIdle) && (state_q != StFin);
    done     = (state_q == StFin);
  end

endmodule
